// File: rtl/axi_lite_stream_writer_if.sv
// AXI-Lite bus bundle for the stream writer: write channels plus the tied-off
// read-address/read-data controls.
interface axi_lite_stream_writer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    ar_valid;
  logic                    r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_valid, r_ready
  );

  modport slave (
    input  aw_addr, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_valid, r_ready
  );
endinterface

// File: rtl/axi_lite_stream_writer.sv
// AXI-Lite master draining a 32-bit valid/ready stream into memory, one word
// per write transaction at base + N*stride. One write outstanding at a time.
module axi_lite_stream_writer #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned SIZE_WIDTH     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      execute_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [SIZE_WIDTH-1:0]     size_i,
  input  logic [SIZE_WIDTH-1:0]     stride_i,
  input  logic [31:0]               data_i,
  input  logic                      data_valid_i,
  output logic                      data_ready_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic                      busy_o,
  axi_lite_stream_writer_if.master  m_axi
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_ISSUE,
    S_WAIT_B,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [SIZE_WIDTH-1:0]     remaining_q, remaining_d;
  logic [SIZE_WIDTH-1:0]     stride_q, stride_d;
  logic [31:0]               data_q, data_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      error_q, error_d;

  logic                      aw_valid, w_valid, b_ready, data_ready, done;
  logic                      upper_lane;

  // State and datapath registers; async reset clears everything so valids drop at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      stride_q    <= '0;
      data_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      stride_q    <= stride_d;
      data_q      <= data_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      error_q     <= error_d;
    end
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    stride_d    = stride_q;
    data_d      = data_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    error_d     = error_q;
    aw_valid    = 1'b0;
    w_valid     = 1'b0;
    b_ready     = 1'b0;
    data_ready  = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (execute_i) begin
          // Word alignment is forced by dropping the two low bits of address and stride
          cur_addr_d  = {addr_i[AXI_ADDR_WIDTH-1:2], 2'b00};
          remaining_d = size_i;
          stride_d    = {stride_i[SIZE_WIDTH-1:2], 2'b00};
          error_d     = 1'b0;
          state_d     = (size_i == '0) ? S_DONE : S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        data_ready = 1'b1;
        if (data_valid_i) begin
          data_d    = data_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Each channel's valid stays up only until its own handshake completes
        aw_valid = ~aw_done_q;
        w_valid  = ~w_done_q;
        if (!aw_done_q && m_axi.aw_ready) aw_done_d = 1'b1;
        if (!w_done_q && m_axi.w_ready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        b_ready = 1'b1;
        if (m_axi.b_valid) begin
          if (m_axi.b_resp != 2'b00) error_d = 1'b1;
          cur_addr_d  = cur_addr_q + AXI_ADDR_WIDTH'(stride_q);
          remaining_d = remaining_q - SIZE_WIDTH'(1);
          state_d     = (remaining_q == SIZE_WIDTH'(1)) ? S_DONE : S_WAIT_DATA;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign upper_lane = cur_addr_q[2];

  assign data_ready_o = data_ready;
  assign done_o       = done;
  assign error_o      = error_q;
  assign busy_o       = (state_q != S_IDLE);

  assign m_axi.aw_addr  = {cur_addr_q[AXI_ADDR_WIDTH-1:3], 3'b000};
  assign m_axi.aw_prot  = 3'b000;
  assign m_axi.aw_valid = aw_valid;
  assign m_axi.w_data   = upper_lane ? {data_q, {(AXI_DATA_WIDTH-32){1'b0}}}
                                     : {{(AXI_DATA_WIDTH-32){1'b0}}, data_q};
  assign m_axi.w_strb   = (state_q != S_ISSUE) ? '0
                        : upper_lane ? {{(STRB_W/2){1'b1}}, {(STRB_W/2){1'b0}}}
                                     : {{(STRB_W/2){1'b0}}, {(STRB_W/2){1'b1}}};
  assign m_axi.w_valid  = w_valid;
  assign m_axi.b_ready  = b_ready;
  assign m_axi.ar_addr  = '0;
  assign m_axi.ar_prot  = 3'b000;
  assign m_axi.ar_valid = 1'b0;
  assign m_axi.r_ready  = 1'b0;

endmodule

// File: tb/tb_axi_lite_stream_writer.sv
// Bench for axi_lite_stream_writer: jobs issued with randomized data, a
// latency-configurable AXI-Lite slave, and a scoreboard monitor that pairs
// AW/W handshakes against writes predicted from base + N*stride arithmetic.
module tb_axi_lite_stream_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        execute;
  logic [31:0] addr_i;
  logic [15:0] size_i;
  logic [15:0] stride_i;
  logic [31:0] data_i;
  logic        data_valid;
  logic        data_ready;
  logic        done_o;
  logic        error_o;
  logic        busy_o;

  always #5 clk = ~clk;

  axi_lite_stream_writer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) axi ();

  axi_lite_stream_writer #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(64),
    .SIZE_WIDTH    (16)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .execute_i   (execute),
    .addr_i      (addr_i),
    .size_i      (size_i),
    .stride_i    (stride_i),
    .data_i      (data_i),
    .data_valid_i(data_valid),
    .data_ready_o(data_ready),
    .done_o      (done_o),
    .error_o     (error_o),
    .busy_o      (busy_o),
    .m_axi       (axi)
  );

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } wr_t;

  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int b_cnt = 0;

  // slave configuration
  int       aw_lat = 0, w_lat = 0, b_lat = 0;
  int       err_idx = 99;
  logic [1:0] err_resp = 2'b10;
  int       txn_idx = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endfunction

  // AXI-Lite slave with per-channel ready latency and configurable BRESP
  initial begin : slave
    logic aw_hs, w_hs, b_hs, aw_got, w_got;
    int   aw_cnt, w_cnt, bc;
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
    axi.b_valid = 1'b0;  axi.b_resp = 2'b00;
    aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0; bc = 0;
    forever begin
      @(negedge clk);
      aw_hs = axi.aw_valid && axi.aw_ready;
      w_hs  = axi.w_valid && axi.w_ready;
      b_hs  = axi.b_valid && axi.b_ready;
      @(posedge clk);
      #1;
      if (rst) begin
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0; axi.b_resp = 2'b00;
        aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0; bc = 0;
      end else begin
        if (aw_hs) aw_got = 1'b1;
        if (w_hs)  w_got  = 1'b1;
        if (b_hs) begin
          axi.b_valid = 1'b0; axi.b_resp = 2'b00;
          aw_got = 1'b0; w_got = 1'b0; bc = 0;
        end
        if (axi.aw_valid) begin axi.aw_ready = (aw_cnt >= aw_lat); aw_cnt++; end
        else begin axi.aw_ready = 1'b0; aw_cnt = 0; end
        if (axi.w_valid) begin axi.w_ready = (w_cnt >= w_lat); w_cnt++; end
        else begin axi.w_ready = 1'b0; w_cnt = 0; end
        if (aw_got && w_got && !axi.b_valid && !b_hs) begin
          if (bc >= b_lat) begin
            axi.b_valid = 1'b1;
            axi.b_resp  = (txn_idx == err_idx) ? err_resp : 2'b00;
            txn_idx++;
          end else bc++;
        end
      end
    end
  end

  // Scoreboard monitor: pairs AW and W handshakes and checks against predictions
  initial begin : monitor
    logic [31:0] got_aw[$];
    logic [63:0] got_wd[$];
    logic [7:0]  got_ws[$];
    logic        aw_hold, w_hold;
    logic [31:0] aw_held;
    logic [63:0] wd_held;
    logic [7:0]  ws_held;
    wr_t         e;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    aw_hold = 1'b0; w_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        got_aw.delete(); got_wd.delete(); got_ws.delete();
        aw_hold = 1'b0; w_hold = 1'b0;
      end else begin
        if (aw_hold) begin
          check("aw_valid_held", axi.aw_valid, 1);
          check("aw_addr_stable", axi.aw_addr, aw_held);
        end
        if (w_hold) begin
          check("w_valid_held", axi.w_valid, 1);
          check("w_data_stable", axi.w_data, wd_held);
          check("w_strb_stable", axi.w_strb, ws_held);
        end
        aw_hold = axi.aw_valid && !axi.aw_ready; aw_held = axi.aw_addr;
        w_hold  = axi.w_valid && !axi.w_ready;   wd_held = axi.w_data; ws_held = axi.w_strb;
        if (axi.aw_valid && axi.aw_ready) got_aw.push_back(axi.aw_addr);
        if (axi.w_valid && axi.w_ready) begin
          got_wd.push_back(axi.w_data);
          got_ws.push_back(axi.w_strb);
        end
        while (got_aw.size() > 0 && got_wd.size() > 0) begin
          a = got_aw.pop_front(); d = got_wd.pop_front(); s = got_ws.pop_front();
          if (exp_q.size() == 0) fail_now("unexpected_write");
          else begin
            e = exp_q.pop_front();
            check("aw_addr", a, e.addr);
            check("w_data", d, e.data);
            check("w_strb", s, e.strb);
          end
        end
        if (axi.b_valid && axi.b_ready) b_cnt++;
        if (done_o) done_cnt++;
        if (busy_o)
          check("ready_exclusive", data_ready && (axi.aw_valid || axi.w_valid || axi.b_ready), 0);
      end
    end
  end

  task automatic check_idle_outputs(string tag);
    check({tag, "_data_ready"}, data_ready, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_aw_valid"}, axi.aw_valid, 0);
    check({tag, "_w_valid"}, axi.w_valid, 0);
    check({tag, "_b_ready"}, axi.b_ready, 0);
    check({tag, "_w_strb"}, axi.w_strb, 0);
    check({tag, "_aw_prot"}, axi.aw_prot, 0);
    check({tag, "_ar_valid"}, axi.ar_valid, 0);
    check({tag, "_r_ready"}, axi.r_ready, 0);
    check({tag, "_ar_addr"}, axi.ar_addr, 0);
    check({tag, "_ar_prot"}, axi.ar_prot, 0);
  endtask

  task automatic run_job(input logic [31:0] addr, input int size, input logic [15:0] stride,
                         input int gap, input int eidx, input bit lat_chk);
    logic [31:0] words[$];
    logic [31:0] w, a;
    wr_t         wr;
    int          done0, b0, cnt;
    bit          ok;
    err_idx = eidx;
    txn_idx = 0;
    for (int i = 0; i < size; i++) begin
      w = $urandom;
      words.push_back(w);
      a = (addr & 32'hFFFF_FFFC) + 32'(i) * {16'h0, stride & 16'hFFFC};
      wr.addr = a & 32'hFFFF_FFF8;
      wr.data = a[2] ? {w, 32'h0} : {32'h0, w};
      wr.strb = a[2] ? 8'hF0 : 8'h0F;
      exp_q.push_back(wr);
    end
    done0 = done_cnt;
    b0    = b_cnt;
    @(posedge clk); #1;
    execute = 1'b1; addr_i = addr; size_i = 16'(size); stride_i = stride;
    @(posedge clk); #1;
    execute = 1'b0; addr_i = $urandom; size_i = 16'($urandom); stride_i = 16'($urandom);
    @(negedge clk);
    check("job_busy", busy_o, 1);
    check("job_done_early", done_o, (size == 0));
    check("job_error_cleared", error_o, 0);
    for (int i = 0; i < size; i++) begin
      // execute pulses while busy must be ignored
      repeat (gap) begin
        @(posedge clk); #1;
        execute = 1'b1; addr_i = $urandom; size_i = 16'($urandom); stride_i = 16'($urandom);
      end
      @(posedge clk); #1;
      execute = 1'b0; data_valid = 1'b1; data_i = words[i];
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (data_ready) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now("stream_ready_timeout");
      @(posedge clk); #1;
      data_valid = 1'b0; data_i = $urandom;
      if (lat_chk && i < size - 1) begin
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          cnt++;
          if (cnt == 1) check("aw_valid_next_cycle", axi.aw_valid && axi.w_valid, 1);
          if (data_ready) break;
        end
        check("word_latency", cnt, 3);
      end
    end
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("job_done_timeout");
    check("done_pulses", done_cnt - done0, 1);
    check("b_count", b_cnt - b0, size);
    check("writes_outstanding", exp_q.size(), 0);
    check("job_error", error_o, (eidx < size));
    check("done_low_after", done_o, 0);
  endtask

  initial begin : stimulus
    bit ok;
    rst = 1'b1; execute = 1'b0; addr_i = '0; size_i = '0; stride_i = '0;
    data_i = '0; data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_idle_outputs("in_reset");
    check("in_reset_error", error_o, 0);
    check("in_reset_aw_addr", axi.aw_addr, 0);
    check("in_reset_w_data", axi.w_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // basic zero-wait job with latency checks
    run_job(32'h8000_0000, 4, 16'd4, 0, 99, 1'b1);
    // stride 8 from an upper-lane address
    run_job(32'h8300_0004, 3, 16'd8, 0, 99, 1'b0);
    // split handshakes in both orders
    aw_lat = 0; w_lat = 3;
    run_job(32'h0000_1000, 2, 16'd4, 0, 99, 1'b0);
    aw_lat = 2; w_lat = 0;
    run_job(32'h0000_2004, 2, 16'd12, 0, 99, 1'b0);
    // stream backpressure with slow B
    aw_lat = 0; w_lat = 0; b_lat = 2;
    run_job(32'h4000_0010, 3, 16'd4, 5, 99, 1'b0);
    b_lat = 0;
    // SLVERR on second write, sticky afterwards, cleared by next job
    err_resp = 2'b10;
    run_job(32'h1000_0000, 4, 16'd4, 0, 1, 1'b0);
    repeat (3) @(negedge clk);
    check("error_sticky", error_o, 1);
    run_job(32'h1000_0100, 1, 16'd4, 0, 99, 1'b0);
    // empty job
    run_job(32'h2000_0000, 0, 16'd4, 0, 99, 1'b0);
    // address wrap, with unaligned low bits that must be ignored
    run_job(32'hFFFF_FFF8, 2, 16'd8, 0, 99, 1'b0);
    run_job(32'h0000_0103, 3, 16'd7, 0, 99, 1'b0);

    // reset in the middle of an AXI issue
    aw_lat = 5; w_lat = 5; err_idx = 99;
    @(posedge clk); #1;
    execute = 1'b1; addr_i = 32'h5000_0000; size_i = 16'd2; stride_i = 16'd4;
    @(posedge clk); #1;
    execute = 1'b0; data_valid = 1'b1; data_i = 32'hDEAD_BEEF;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (axi.aw_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("reset_test_no_issue");
    data_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_async_aw_valid", axi.aw_valid, 0);
    check("rst_async_w_valid", axi.w_valid, 0);
    check("rst_async_busy", busy_o, 0);
    check("rst_async_strb", axi.w_strb, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    aw_lat = 0; w_lat = 0;
    @(negedge clk);
    check_idle_outputs("after_midjob_reset");
    run_job(32'h5000_0000, 2, 16'd4, 0, 99, 1'b1);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      aw_lat   = $urandom_range(0, 3);
      w_lat    = $urandom_range(0, 3);
      b_lat    = $urandom_range(0, 2);
      err_resp = 2'($urandom_range(1, 3));
      run_job($urandom, $urandom_range(1, 5), 16'($urandom_range(0, 64)),
              $urandom_range(0, 3), $urandom_range(0, 7), 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
